// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C target: FSM state encoding, byte
// width, general-call address and the bit-order aware shift helpers used by
// both the receive and transmit paths.
package i2c_slave_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [6:0] GCALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_DATA  = 3'd3,
    RX_ACK   = 3'd4,
    TX_DATA  = 3'd5,
    TX_ACK   = 3'd6,
    WAIT     = 3'd7
  } state_t;

  // Shift a sampled bit into a byte; MSB-first bits enter at the bottom.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sh,
                                                 input logic              b,
                                                 input logic              msb_first);
    if (msb_first) begin
      return {sh[BYTE_W-2:0], b};
    end else begin
      return {b, sh[BYTE_W-1:1]};
    end
  endfunction

  // Bit that goes on the wire next for the given order.
  function automatic logic first_bit(input logic [BYTE_W-1:0] d,
                                     input logic              msb_first);
    if (msb_first) begin
      return d[BYTE_W-1];
    end else begin
      return d[0];
    end
  endfunction

  // Drop the bit just sent so the next one sits at the output end.
  function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] d,
                                                  input logic              msb_first);
    if (msb_first) begin
      return {d[BYTE_W-2:0], 1'b0};
    end else begin
      return {1'b0, d[BYTE_W-1:1]};
    end
  endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Byte-level user side of the I2C target. The target uses the slave modport;
// whatever supplies read data and consumes write data uses the master modport.
interface i2c_slave_if;
  import i2c_slave_pkg::*;

  logic              msb_lsb;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_load;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rw;
  logic              busy;
  logic              end_trans;

  modport slave (
    input  msb_lsb, tx_byte,
    output tx_load, rx_byte, rx_valid, rw, busy, end_trans
  );

  modport master (
    output msb_lsb, tx_byte,
    input  tx_load, rx_byte, rx_valid, rw, busy, end_trans
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Conditions one bus line: 2-FF synchroniser, then a stability filter that
// only accepts a new level after FILT_LEN consecutive cycles, then single
// cycle rise/fall pulses. Pin-to-filtered latency is 2+FILT_LEN cycles.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic i_line,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_filt;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchroniser; idles high like the bus.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only once it has been stable for FILT_LEN cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_filt <= 1'b1;
      r_prev <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_prev <= r_filt;
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_filt & ~r_prev;
  assign o_fall = ~r_filt & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: filters SCL/SDA, detects START/STOP, matches a 7-bit address,
// ACKs, receives write bytes and serves read bytes on an open-drain SDA.
// Optional feature macro: I2C_SLV_GCALL_EN (also accept general-call writes).
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         I2C_FREQ = 100_000,
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave usr
);

  if (CLK_FREQ < 20 * I2C_FREQ) begin : g_freq_chk
    $error("i2c_slave: CLK_FREQ must be at least 20 x I2C_FREQ");
  end

`ifdef I2C_SLV_GCALL_EN
  localparam logic GCALL_ON = 1'b1;
`else
  localparam logic GCALL_ON = 1'b0;
`endif

  logic w_scl_f, w_scl_rise, w_scl_fall;
  logic w_sda_f, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_match;
  logic [BYTE_W-1:0] w_addr_byte, w_data_in;

  state_t            r_state, w_state_nx;
  logic [2:0]        r_cnt, w_cnt_nx;
  logic [BYTE_W-1:0] r_shift, w_shift_nx;
  logic [BYTE_W-1:0] r_tx_sh, w_tx_sh_nx;
  logic [BYTE_W-1:0] r_rx_byte, w_rx_byte_nx;
  logic r_sda_low, w_sda_low_nx;
  logic r_busy, w_busy_nx;
  logic r_rw, w_rw_nx;
  logic r_mack, w_mack_nx;
  logic r_rx_valid, w_rx_valid_nx;
  logic r_tx_load, w_tx_load_nx;
  logic r_end_trans, w_end_trans_nx;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .arst(arst), .i_line(scl),
    .o_filt(w_scl_f), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .arst(arst), .i_line(sda),
    .o_filt(w_sda_f), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high.
  assign w_start = w_sda_fall & w_scl_f;
  assign w_stop  = w_sda_rise & w_scl_f;

  // Address byte is always MSB first; data follows msb_lsb.
  assign w_addr_byte  = shift_in(r_shift, w_sda_f, 1'b1);
  assign w_data_in    = shift_in(r_shift, w_sda_f, usr.msb_lsb);
  assign w_addr_match = (w_addr_byte[7:1] == SLV_ADDR) |
                        (GCALL_ON & (w_addr_byte == {GCALL_ADDR, 1'b0}));

  // Next-state and next-output logic; STOP/START override any bit event.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_tx_sh_nx     = r_tx_sh;
    w_rx_byte_nx   = r_rx_byte;
    w_sda_low_nx   = r_sda_low;
    w_busy_nx      = r_busy;
    w_rw_nx        = r_rw;
    w_mack_nx      = r_mack;
    w_rx_valid_nx  = 1'b0;
    w_tx_load_nx   = 1'b0;
    w_end_trans_nx = 1'b0;

    if (w_stop) begin
      w_state_nx     = IDLE;
      w_sda_low_nx   = 1'b0;
      w_busy_nx      = 1'b0;
      w_cnt_nx       = 3'd0;
      w_end_trans_nx = r_busy;
    end else if (w_start) begin
      w_state_nx   = ADDR;
      w_sda_low_nx = 1'b0;
      w_busy_nx    = 1'b0;
      w_cnt_nx     = 3'd0;
    end else begin
      case (r_state)
        IDLE: w_state_nx = IDLE;
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_addr_byte;
            w_cnt_nx   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (w_addr_match) begin
                w_state_nx = ADDR_ACK;
                w_rw_nx    = w_addr_byte[0];
              end else begin
                w_state_nx = WAIT;
              end
            end else begin
              w_state_nx = ADDR;
            end
          end else begin
            w_state_nx = ADDR;
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_sda_low_nx = 1'b1;
              w_busy_nx    = 1'b1;
            end else begin
              w_cnt_nx = 3'd0;
              if (r_rw) begin
                w_tx_load_nx = 1'b1;
                w_sda_low_nx = ~first_bit(usr.tx_byte, usr.msb_lsb);
                w_tx_sh_nx   = shift_out(usr.tx_byte, usr.msb_lsb);
                w_state_nx   = TX_DATA;
              end else begin
                w_sda_low_nx = 1'b0;
                w_state_nx   = RX_DATA;
              end
            end
          end else begin
            w_state_nx = ADDR_ACK;
          end
        end
        RX_DATA: begin
          if (w_scl_rise) begin
            w_shift_nx = w_data_in;
            w_cnt_nx   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_rx_byte_nx  = w_data_in;
              w_rx_valid_nx = 1'b1;
              w_state_nx    = RX_ACK;
            end else begin
              w_state_nx = RX_DATA;
            end
          end else begin
            w_state_nx = RX_DATA;
          end
        end
        RX_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_sda_low_nx = 1'b1;
            end else begin
              w_sda_low_nx = 1'b0;
              w_cnt_nx     = 3'd0;
              w_state_nx   = RX_DATA;
            end
          end else begin
            w_state_nx = RX_ACK;
          end
        end
        TX_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_low_nx = 1'b0;
              w_state_nx   = TX_ACK;
            end else begin
              w_sda_low_nx = ~first_bit(r_tx_sh, usr.msb_lsb);
              w_tx_sh_nx   = shift_out(r_tx_sh, usr.msb_lsb);
            end
          end else begin
            w_state_nx = TX_DATA;
          end
        end
        TX_ACK: begin
          if (w_scl_rise) begin
            w_mack_nx = w_sda_f;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_tx_load_nx = 1'b1;
              w_sda_low_nx = ~first_bit(usr.tx_byte, usr.msb_lsb);
              w_tx_sh_nx   = shift_out(usr.tx_byte, usr.msb_lsb);
              w_cnt_nx     = 3'd0;
              w_state_nx   = TX_DATA;
            end else begin
              w_sda_low_nx = 1'b0;
              w_state_nx   = WAIT;
            end
          end else begin
            w_state_nx = TX_ACK;
          end
        end
        WAIT: w_state_nx = WAIT;
        default: begin
          w_state_nx   = IDLE;
          w_sda_low_nx = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 8'h00;
      r_tx_sh     <= 8'h00;
      r_rx_byte   <= 8'h00;
      r_sda_low   <= 1'b0;
      r_busy      <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_end_trans <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_tx_sh     <= w_tx_sh_nx;
      r_rx_byte   <= w_rx_byte_nx;
      r_sda_low   <= w_sda_low_nx;
      r_busy      <= w_busy_nx;
      r_rw        <= w_rw_nx;
      r_mack      <= w_mack_nx;
      r_rx_valid  <= w_rx_valid_nx;
      r_tx_load   <= w_tx_load_nx;
      r_end_trans <= w_end_trans_nx;
    end
  end

  assign sda           = r_sda_low ? 1'b0 : 1'bz;
  assign usr.rx_byte   = r_rx_byte;
  assign usr.rx_valid  = r_rx_valid;
  assign usr.tx_load   = r_tx_load;
  assign usr.rw        = r_rw;
  assign usr.busy      = r_busy;
  assign usr.end_trans = r_end_trans;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master plus a vector table
// of write transfers, followed by hand-written read, glitch, repeated-START
// and asynchronous-reset sequences.
module tb_i2c_slave;

  localparam int Q = 20;  // clk cycles per quarter SCL period

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       msb;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_rxv;
    logic [7:0] exp_rx;
    logic       exp_busy;
    int         exp_end;
  } vec_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_if u_if();

  i2c_slave #(
    .CLK_FREQ(100_000_000), .I2C_FREQ(100_000), .SLV_ADDR(7'h50), .FILT_LEN(3)
  ) dut (
    .clk(clk), .arst(arst), .scl(scl), .sda(sda), .usr(u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_txl = 0;
  int n_end = 0;
  vec_t vecs[5];

  // Count user-side pulses away from the active edge.
  always @(negedge clk) begin
    if (u_if.rx_valid)  n_rxv <= n_rxv + 1;
    if (u_if.tx_load)   n_txl <= n_txl + 1;
    if (u_if.end_trans) n_end <= n_end + 1;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One bit slot, entered and left with SCL just driven low; s is SDA seen mid-high.
  task automatic xfer_bit(input logic b, input logic glitch, output logic s);
    tick(Q);
    m_low = ~b;
    if (glitch) begin
      tick(10);
      scl = 1'b1;
      tick(2);
      scl = 1'b0;
      tick(Q - 12);
    end else begin
      tick(Q);
    end
    scl = 1'b1;
    tick(Q);
    s = sda;
    tick(Q);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl) begin
      tick(Q);
      m_low = 1'b1;
      tick(Q);
      scl = 1'b0;
    end else begin
      tick(Q);
      m_low = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_low = 1'b1;
      tick(Q);
      scl = 1'b0;
    end
  endtask

  task automatic stop_cond();
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    m_low = 1'b0;
    tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic msb, input int gbit);
    logic s;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(msb ? d[7 - i] : d[i], (i == gbit), s);
    end
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    xfer_bit(ack, 1'b0, s);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic a;
    logic dk;
    int   rxv0;
    int   end0;
    rxv0 = n_rxv;
    end0 = n_end;
    u_if.msb_lsb = v.msb;
    start_cond();
    send_byte(v.addr, 1'b1, -1);
    xfer_bit(1'b1, 1'b0, a);
    chk($sformatf("v%0d_addr_ack", idx), a, v.exp_aack);
    send_byte(v.data, v.msb, -1);
    xfer_bit(1'b1, 1'b0, dk);
    chk($sformatf("v%0d_data_ack", idx), dk, v.exp_dack);
    chk($sformatf("v%0d_busy", idx), u_if.busy, v.exp_busy);
    chk($sformatf("v%0d_rw", idx), u_if.rw, 1'b0);
    chk($sformatf("v%0d_rx_valid_cnt", idx), n_rxv - rxv0, v.exp_rxv);
    chk($sformatf("v%0d_rx_byte", idx), u_if.rx_byte, v.exp_rx);
    stop_cond();
    chk($sformatf("v%0d_end_trans_cnt", idx), n_end - end0, v.exp_end);
    chk($sformatf("v%0d_busy_after_stop", idx), u_if.busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       s;
    int         c0;
    int         c1;
    int         c2;

    vecs[0] = '{8'hA0, 8'h55, 1'b1, 1'b0, 1'b0, 1, 8'h55, 1'b1, 1};
    vecs[1] = '{8'hA2, 8'hAA, 1'b1, 1'b1, 1'b1, 0, 8'h55, 1'b0, 0};
    vecs[2] = '{8'hA0, 8'h01, 1'b0, 1'b0, 1'b0, 1, 8'h01, 1'b1, 1};
    vecs[3] = '{8'hA0, 8'hC3, 1'b0, 1'b0, 1'b0, 1, 8'hC3, 1'b1, 1};
`ifdef I2C_SLV_GCALL_EN
    vecs[4] = '{8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b1, 1};
`else
    vecs[4] = '{8'h00, 8'h5A, 1'b1, 1'b1, 1'b1, 0, 8'hC3, 1'b0, 0};
`endif

    u_if.msb_lsb = 1'b1;
    u_if.tx_byte = 8'h3C;
    tick(5);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_rw", u_if.rw, 1'b0);
    chk("rst_rx_byte", u_if.rx_byte, 8'h00);
    chk("rst_rx_valid", u_if.rx_valid, 1'b0);
    chk("rst_tx_load", u_if.tx_load, 1'b0);
    chk("rst_end_trans", u_if.end_trans, 1'b0);
    arst = 1'b0;
    tick(10);

    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
    end

    // Read: 3C acked by master, C3 nacked.
    u_if.msb_lsb = 1'b1;
    u_if.tx_byte = 8'h3C;
    c0 = n_txl;
    c1 = n_end;
    start_cond();
    send_byte(8'hA1, 1'b1, -1);
    xfer_bit(1'b1, 1'b0, s);
    chk("rd_addr_ack", s, 1'b0);
    chk("rd_rw", u_if.rw, 1'b1);
    chk("rd_busy", u_if.busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 1'b0, s);
      rd = {rd[6:0], s};
    end
    u_if.tx_byte = 8'hC3;
    xfer_bit(1'b0, 1'b0, s);
    chk("rd_byte1", rd, 8'h3C);
    read_byte(1'b1, rd);
    chk("rd_byte2", rd, 8'hC3);
    chk("rd_tx_load_cnt", n_txl - c0, 2);
    tick(Q);
    chk("rd_sda_released", sda, 1'b1);
    stop_cond();
    chk("rd_end_trans_cnt", n_end - c1, 1);

    // Two-cycle SCL glitch inside a write byte.
    u_if.msb_lsb = 1'b1;
    c0 = n_rxv;
    start_cond();
    send_byte(8'hA0, 1'b1, -1);
    xfer_bit(1'b1, 1'b0, s);
    chk("gl_addr_ack", s, 1'b0);
    send_byte(8'h96, 1'b1, 3);
    xfer_bit(1'b1, 1'b0, s);
    chk("gl_data_ack", s, 1'b0);
    chk("gl_rx_byte", u_if.rx_byte, 8'h96);
    chk("gl_rx_valid_cnt", n_rxv - c0, 1);
    stop_cond();

    // Partial write byte, repeated START, then read address.
    c0 = n_rxv;
    c1 = n_end;
    start_cond();
    send_byte(8'hA0, 1'b1, -1);
    xfer_bit(1'b1, 1'b0, s);
    chk("rs_addr1_ack", s, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer_bit(i[0], 1'b0, s);
    end
    chk("rs_busy_before", u_if.busy, 1'b1);
    start_cond();
    chk("rs_busy_after_start", u_if.busy, 1'b0);
    send_byte(8'hA1, 1'b1, -1);
    xfer_bit(1'b1, 1'b0, s);
    chk("rs_addr2_ack", s, 1'b0);
    chk("rs_rw", u_if.rw, 1'b1);
    chk("rs_rx_valid_cnt", n_rxv - c0, 0);
    chk("rs_end_trans_mid", n_end - c1, 0);
    read_byte(1'b1, rd);
    stop_cond();
    chk("rs_rx_byte_held", u_if.rx_byte, 8'h96);

    // Asynchronous reset while the target holds SDA low in the address ACK slot.
    start_cond();
    send_byte(8'hA1, 1'b1, -1);
    tick(Q);
    m_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    chk("ar_sda_before", sda, 1'b0);
    chk("ar_rw_before", u_if.rw, 1'b1);
    arst = 1'b1;
    #1;
    chk("ar_sda_released", sda, 1'b1);
    chk("ar_busy", u_if.busy, 1'b0);
    chk("ar_rw", u_if.rw, 1'b0);
    chk("ar_rx_byte", u_if.rx_byte, 8'h00);
    chk("ar_rx_valid", u_if.rx_valid, 1'b0);
    chk("ar_tx_load", u_if.tx_load, 1'b0);
    chk("ar_end_trans", u_if.end_trans, 1'b0);
    tick(3);
    arst = 1'b0;
    tick(2 * Q);

    // Target works again after reset.
    run_vec(9, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
